// File: rtl/fantasticfft_fft8_unloader.sv
// Ping-pong unloader for the fft8 result bus: captures whole frames on result_valid
// and streams them out one complex bin per valid/ready beat.
module fantasticfft_fft8_unloader #(
    parameter int INT_SIZE  = 8,
    parameter int FRAC_SIZE = 8,
    parameter int NUM_BINS  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y0,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y1,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y2,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y3,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y4,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y5,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y6,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y7,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y0_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y1_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y2_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y3_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y4_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y5_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y6_i,
    input  logic [INT_SIZE+FRAC_SIZE-1:0] y7_i,
    input  logic                          result_valid,
    output logic [INT_SIZE+FRAC_SIZE-1:0] out_re,
    output logic [INT_SIZE+FRAC_SIZE-1:0] out_im,
    output logic [2:0]                    out_idx,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [7:0]                    drop_count
);

    localparam int         W        = INT_SIZE + FRAC_SIZE;
    localparam logic [2:0] LAST_BIN = 3'(NUM_BINS - 1);

    // State encodes how many complete frames are held in the two slots.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         wrPtr_q, wrPtr_d;
    logic         rdPtr_q, rdPtr_d;
    logic [2:0]   binIdx_q, binIdx_d;
    logic         overflow_q, overflow_d;
    logic [7:0]   dropCount_q, dropCount_d;
    logic         outValid_q;
    logic         outLast_q;

    logic [W-1:0] slotRe_q [2][8];
    logic [W-1:0] slotIm_q [2][8];
    logic [W-1:0] frameRe [8];
    logic [W-1:0] frameIm [8];

    logic         transfer;
    logic         retire;
    logic         capture;
    logic         drop;

    assign frameRe[0] = y0;
    assign frameRe[1] = y1;
    assign frameRe[2] = y2;
    assign frameRe[3] = y3;
    assign frameRe[4] = y4;
    assign frameRe[5] = y5;
    assign frameRe[6] = y6;
    assign frameRe[7] = y7;
    assign frameIm[0] = y0_i;
    assign frameIm[1] = y1_i;
    assign frameIm[2] = y2_i;
    assign frameIm[3] = y3_i;
    assign frameIm[4] = y4_i;
    assign frameIm[5] = y5_i;
    assign frameIm[6] = y6_i;
    assign frameIm[7] = y7_i;

    // A slot freed by a last-bin transfer can be refilled on the same edge.
    assign transfer = outValid_q & out_ready;
    assign retire   = transfer & (binIdx_q == LAST_BIN);
    assign capture  = result_valid & ((state_q != FULL) | retire);
    assign drop     = result_valid & (state_q == FULL) & ~retire;

    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q ^ capture;
        rdPtr_d     = rdPtr_q ^ retire;
        binIdx_d    = binIdx_q;
        overflow_d  = overflow_q;
        dropCount_d = dropCount_q;

        if (capture && !retire) begin
            state_d = (state_q == IDLE) ? ONE : FULL;
        end else if (retire && !capture) begin
            state_d = (state_q == FULL) ? ONE : IDLE;
        end

        if (transfer) begin
            binIdx_d = retire ? 3'd0 : binIdx_q + 3'd1;
        end

        // A drop in the same cycle as a clear still leaves a record of itself.
        if (overflow_clr) begin
            overflow_d  = drop;
            dropCount_d = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow_d  = 1'b1;
            dropCount_d = (dropCount_q == 8'hFF) ? dropCount_q : dropCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
            binIdx_q    <= 3'd0;
            overflow_q  <= 1'b0;
            dropCount_q <= 8'd0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            binIdx_q    <= binIdx_d;
            overflow_q  <= overflow_d;
            dropCount_q <= dropCount_d;
            outValid_q  <= (state_d != IDLE);
            outLast_q   <= (state_d != IDLE) && (binIdx_d == LAST_BIN);
        end
    end

    // Frame storage carries no reset; validity is tracked entirely by state_q.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < 8; k++) begin
                slotRe_q[wrPtr_q][k] <= frameRe[k];
                slotIm_q[wrPtr_q][k] <= frameIm[k];
            end
        end
    end

    assign out_valid  = outValid_q;
    assign out_last   = outLast_q;
    assign out_idx    = binIdx_q;
    assign out_re     = outValid_q ? slotRe_q[rdPtr_q][binIdx_q] : '0;
    assign out_im     = outValid_q ? slotIm_q[rdPtr_q][binIdx_q] : '0;
    assign overflow   = overflow_q;
    assign drop_count = dropCount_q;

endmodule

// File: tb/tb_fantasticfft_fft8_unloader.sv
// Directed bench for the fft8 unloader: an 8-bin and a 5-bin instance checked
// against a queue of expected beats.
module tb_fantasticfft_fft8_unloader;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    logic        clock = 1'b0;
    logic        rst8N, rst5N, rv8, rv5, outReady, ovfClr;
    logic [15:0] yRe [8];
    logic [15:0] yIm [8];

    logic        v8, last8, ovf8, v5, last5, ovf5;
    logic [2:0]  idx8, idx5;
    logic [15:0] re8, im8, re5, im5;
    logic [7:0]  drop8, drop5;

    logic [15:0] frameRe [8];
    logic [15:0] frameIm [8];
    beat_t       sb [$];

    int          checks = 0;
    int          errors = 0;
    int          cycles;
    bit          prevStall = 1'b0;
    logic [15:0] prevRe, prevIm;
    logic [2:0]  prevIdx;
    logic        prevLast;
    bit          readyPat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clock = ~clock;

    fantasticfft_fft8_unloader #(.INT_SIZE(8), .FRAC_SIZE(8), .NUM_BINS(8)) dut8 (
        .clk(clock), .rst_n(rst8N),
        .y0(yRe[0]), .y1(yRe[1]), .y2(yRe[2]), .y3(yRe[3]),
        .y4(yRe[4]), .y5(yRe[5]), .y6(yRe[6]), .y7(yRe[7]),
        .y0_i(yIm[0]), .y1_i(yIm[1]), .y2_i(yIm[2]), .y3_i(yIm[3]),
        .y4_i(yIm[4]), .y5_i(yIm[5]), .y6_i(yIm[6]), .y7_i(yIm[7]),
        .result_valid(rv8),
        .out_re(re8), .out_im(im8), .out_idx(idx8), .out_last(last8),
        .out_valid(v8), .out_ready(outReady),
        .overflow(ovf8), .overflow_clr(ovfClr), .drop_count(drop8)
    );

    fantasticfft_fft8_unloader #(.INT_SIZE(8), .FRAC_SIZE(8), .NUM_BINS(5)) dut5 (
        .clk(clock), .rst_n(rst5N),
        .y0(yRe[0]), .y1(yRe[1]), .y2(yRe[2]), .y3(yRe[3]),
        .y4(yRe[4]), .y5(yRe[5]), .y6(yRe[6]), .y7(yRe[7]),
        .y0_i(yIm[0]), .y1_i(yIm[1]), .y2_i(yIm[2]), .y3_i(yIm[3]),
        .y4_i(yIm[4]), .y5_i(yIm[5]), .y6_i(yIm[6]), .y7_i(yIm[7]),
        .result_valid(rv5),
        .out_re(re5), .out_im(im5), .out_idx(idx5), .out_last(last5),
        .out_valid(v5), .out_ready(outReady),
        .overflow(ovf5), .overflow_clr(ovfClr), .drop_count(drop5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: a beat shown with ready high transfers on the coming posedge.
    task automatic checkOutput(input bit useFive);
        logic        v, l;
        logic [2:0]  ix;
        logic [15:0] re, im;
        beat_t       e;
        if (useFive) begin
            v = v5; l = last5; ix = idx5; re = re5; im = im5;
        end else begin
            v = v8; l = last8; ix = idx8; re = re8; im = im8;
        end
        if (prevStall) begin
            check("stall_hold", 64'({v, re, im, ix, l}), 64'({1'b1, prevRe, prevIm, prevIdx, prevLast}));
        end
        if (v && outReady) begin
            check("beat_expected", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("beat_data", 64'({re, im, ix, l}), 64'(e));
            end
        end
        prevStall = v && !outReady;
        prevRe    = re;
        prevIm    = im;
        prevIdx   = ix;
        prevLast  = l;
    endtask

    task automatic tick(input bit useFive);
        checkOutput(useFive);
        @(negedge clock);
    endtask

    task automatic scrambleInputs();
        for (int k = 0; k < 8; k++) begin
            yRe[k] = 16'($urandom);
            yIm[k] = 16'($urandom);
        end
    endtask

    task automatic makeFrame(input bit patterned);
        for (int k = 0; k < 8; k++) begin
            frameRe[k] = patterned ? 16'(k * 'h100) : 16'($urandom);
            frameIm[k] = patterned ? 16'(-(k * 'h80)) : 16'($urandom);
        end
    endtask

    // Presents frameRe/frameIm for one cycle; accepted frames are queued as expected beats.
    task automatic applyStimulus(input bit useFive, input bit accept, input int nb);
        for (int k = 0; k < 8; k++) begin
            yRe[k] = frameRe[k];
            yIm[k] = frameIm[k];
        end
        if (useFive) rv5 = 1'b1;
        else         rv8 = 1'b1;
        if (accept) begin
            for (int k = 0; k < nb; k++) begin
                sb.push_back('{re: frameRe[k], im: frameIm[k], idx: 3'(k), last: (k == nb - 1)});
            end
        end
        tick(useFive);
        rv5 = 1'b0;
        rv8 = 1'b0;
        scrambleInputs();
    endtask

    task automatic drain(input bit useFive, input bit usePattern, input int budget, output int n);
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            outReady = usePattern ? readyPat[n % 6] : 1'b1;
            tick(useFive);
            n++;
        end
        check("drain_complete", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst8N = 1'b0; rst5N = 1'b0; rv8 = 1'b0; rv5 = 1'b0;
        outReady = 1'b0; ovfClr = 1'b0;
        scrambleInputs();
        @(negedge clock);
        @(negedge clock);

        // Reset values.
        check("rst_valid", 64'(v8), 64'(0));
        check("rst_last", 64'(last8), 64'(0));
        check("rst_idx", 64'(idx8), 64'(0));
        check("rst_re", 64'(re8), 64'(0));
        check("rst_im", 64'(im8), 64'(0));
        check("rst_overflow", 64'(ovf8), 64'(0));
        check("rst_drops", 64'(drop8), 64'(0));
        check("rst5_valid", 64'(v5), 64'(0));
        rst8N = 1'b1;
        tick(1'b0);

        // Single frame with the fixed pattern, ready high.
        outReady = 1'b1;
        makeFrame(1'b1);
        applyStimulus(1'b0, 1'b1, 8);
        check("latency_valid", 64'(v8), 64'(1));
        check("latency_idx", 64'(idx8), 64'(0));
        drain(1'b0, 1'b0, 40, cycles);
        check("single_cycles", 64'(cycles), 64'(8));
        check("single_idle", 64'(v8), 64'(0));

        // Backpressure.
        makeFrame(1'b1);
        applyStimulus(1'b0, 1'b1, 8);
        drain(1'b0, 1'b1, 60, cycles);
        outReady = 1'b1;
        check("bp_idle", 64'(v8), 64'(0));

        // Back-to-back frames.
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b1, 8);
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b1, 8);
        drain(1'b0, 1'b0, 40, cycles);
        check("b2b_cycles", 64'(cycles), 64'(15));
        check("b2b_overflow", 64'(ovf8), 64'(0));

        // Overflow, saturation and clear.
        outReady = 1'b0;
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b1, 8);
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b1, 8);
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b0, 8);
        check("ovf_flag", 64'(ovf8), 64'(1));
        check("ovf_count1", 64'(drop8), 64'(1));
        for (int i = 0; i < 254; i++) begin
            makeFrame(1'b0);
            applyStimulus(1'b0, 1'b0, 8);
        end
        check("ovf_count255", 64'(drop8), 64'(255));
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b0, 8);
        check("ovf_saturate", 64'(drop8), 64'(255));
        ovfClr = 1'b1;
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b0, 8);
        check("clr_drop_flag", 64'(ovf8), 64'(1));
        check("clr_drop_count", 64'(drop8), 64'(1));
        tick(1'b0);
        ovfClr = 1'b0;
        check("clr_flag", 64'(ovf8), 64'(0));
        check("clr_count", 64'(drop8), 64'(0));
        drain(1'b0, 1'b0, 40, cycles);
        check("ovf_drain_cycles", 64'(cycles), 64'(16));
        check("ovf_idle", 64'(v8), 64'(0));

        // Capture coinciding with the last-bin transfer of a full buffer.
        outReady = 1'b0;
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b1, 8);
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b1, 8);
        outReady = 1'b1;
        repeat (7) tick(1'b0);
        check("retire_last", 64'({last8, idx8}), 64'({1'b1, 3'd7}));
        makeFrame(1'b0);
        applyStimulus(1'b0, 1'b1, 8);
        drain(1'b0, 1'b0, 40, cycles);
        check("retire_cycles", 64'(cycles), 64'(16));
        check("retire_overflow", 64'(ovf8), 64'(0));
        check("retire_drops", 64'(drop8), 64'(0));

        // Five-bin instance, then reset in the middle of a backlog.
        rst5N = 1'b1;
        tick(1'b1);
        makeFrame(1'b1);
        applyStimulus(1'b1, 1'b1, 5);
        drain(1'b1, 1'b0, 40, cycles);
        check("five_cycles", 64'(cycles), 64'(5));
        check("five_idle", 64'(v5), 64'(0));
        outReady = 1'b0;
        makeFrame(1'b0);
        applyStimulus(1'b1, 1'b1, 5);
        makeFrame(1'b0);
        applyStimulus(1'b1, 1'b1, 5);
        outReady = 1'b1;
        tick(1'b1);
        tick(1'b1);
        check("five_beat2", 64'({v5, idx5}), 64'({1'b1, 3'd2}));
        rst5N = 1'b0;
        outReady = 1'b0;
        sb.delete();
        prevStall = 1'b0;
        @(negedge clock);
        check("rst_mid_valid", 64'(v5), 64'(0));
        check("rst_mid_outputs", 64'({re5, im5, idx5, last5}), 64'(0));
        check("rst_mid_overflow", 64'(ovf5), 64'(0));
        rst5N = 1'b1;
        outReady = 1'b1;
        repeat (6) tick(1'b1);
        check("rst_no_resume", 64'(v5), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
